// File: rtl/ifmap_mem_pkg.sv
// Shared constants for the ifmap write-word layout and bank geometry.
package ifmap_mem_pkg;

  localparam int unsigned DEF_WIDTH  = 45;   // decoder packet width; write word is WIDTH+1
  localparam int unsigned DEF_DATA_W = 36;   // ifmap bits per stored word
  localparam int unsigned DEF_DEPTH  = 111;  // ceil(63*63/36) words per bank
  localparam int unsigned NUM_BANKS  = 2;    // one bank per timestep

  localparam int unsigned SIZE_W = 6;   // ifmap size field width
  localparam int unsigned FIL_W  = 2;   // filter size field width
  localparam int unsigned ADDR_W = 7;   // word address width
  localparam int unsigned CNT_W  = 12;  // per-bank bit counter width

  // Fixed low-side field positions.
  localparam int unsigned TS_BIT   = 0;
  localparam int unsigned SIZE_LSB = 1;
  localparam int unsigned DATA_LSB = 7;

  // High-side field positions depend on the packet width.
  function automatic int unsigned done_bit(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned fil_lsb(input int unsigned width);
    return width - FIL_W;
  endfunction

endpackage

// File: rtl/ifmap_mem_if.sv
// Bus between the instruction decoder / consumer and the ifmap buffer.
// The bank-free strobe is called release_req because 'release' is a reserved word.
interface ifmap_mem_if
  import ifmap_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                              in_valid;
  logic                              in_ready;
  logic [WIDTH:0]                    in_data;
  logic                              rd_en;
  logic                              rd_bank;
  logic [ADDR_W-1:0]                 rd_addr;
  logic [DATA_W-1:0]                 rd_data;
  logic                              rd_valid;
  logic [NUM_BANKS-1:0]              release_req;
  logic [NUM_BANKS-1:0]              bank_full;
  logic [NUM_BANKS-1:0][SIZE_W-1:0]  bank_size;
  logic [FIL_W-1:0]                  fil_size;
  logic                              err;

  modport slave (
    input  in_valid, in_data, rd_en, rd_bank, rd_addr, release_req,
    output in_ready, rd_data, rd_valid, bank_full, bank_size, fil_size, err
  );

  modport master (
    output in_valid, in_data, rd_en, rd_bank, rd_addr, release_req,
    input  in_ready, rd_data, rd_valid, bank_full, bank_size, fil_size, err
  );
endinterface

// File: rtl/ifmap_bank.sv
// One timestep bank: word array, write pointer, bit counter, full flag and
// completion detection. Read port is combinational; the top registers it.
module ifmap_bank
  import ifmap_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SIZE_W-1:0] wr_size,
  input  logic              wr_done,
  input  logic              rel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_word,
  output logic              full,
  output logic [SIZE_W-1:0] size,
  output logic              err_pulse
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              full_q, full_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] first_size_q, first_size_d;

  logic              first_word;
  logic [SIZE_W-1:0] eff_size;
  logic [CNT_W-1:0]  area;
  logic [CNT_W:0]    sum;
  logic              complete;
  logic              overflow;
  logic              store;

  // Completion compare and next-state for pointer, counter and flags.
  always_comb begin
    first_word   = (wr_ptr_q == '0);
    // A size change mid-bank is an error; the first word's size stays in force.
    eff_size     = first_word ? wr_size : first_size_q;
    area         = CNT_W'(eff_size) * CNT_W'(eff_size);
    sum          = {1'b0, bit_cnt_q} + (CNT_W + 1)'(DATA_W);
    complete     = (sum >= {1'b0, area});
    overflow     = (wr_ptr_q >= ADDR_W'(DEPTH));
    store        = wr_en && !overflow;

    wr_ptr_d     = wr_ptr_q;
    bit_cnt_d    = bit_cnt_q;
    full_d       = full_q;
    size_d       = size_q;
    first_size_d = first_size_q;
    err_pulse    = 1'b0;

    if (wr_en) begin
      if (overflow) begin
        // Dropped, pointer does not wrap.
        err_pulse = 1'b1;
      end else begin
        if (first_word) begin
          first_size_d = wr_size;
        end else if (wr_size != first_size_q) begin
          err_pulse = 1'b1;
        end
        if (complete) begin
          full_d    = 1'b1;
          size_d    = eff_size;
          wr_ptr_d  = '0;
          bit_cnt_d = '0;
        end else begin
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          bit_cnt_d = sum[CNT_W-1:0];
          if (wr_done) begin
            err_pulse = 1'b1;
          end
        end
      end
    end

    // A write can never hit a full bank, so release does not race completion.
    if (rel && full_q) begin
      full_d = 1'b0;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      bit_cnt_q    <= '0;
      full_q       <= 1'b0;
      size_q       <= '0;
      first_size_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      bit_cnt_q    <= bit_cnt_d;
      full_q       <= full_d;
      size_q       <= size_d;
      first_size_q <= first_size_d;
    end
  end

  // Word array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (rd_addr < ADDR_W'(DEPTH)) begin
      rd_word = mem[rd_addr];
    end
  end

  assign full = full_q;
  assign size = size_q;

endmodule

// File: rtl/ifmap_mem.sv
// Double-buffered ifmap store: decoder writes fill the bank selected by the
// timestep bit while the consumer reads either bank with one cycle latency.
module ifmap_mem
  import ifmap_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input logic        clk,
  input logic        rst_n,
  ifmap_mem_if.slave bus
);

  localparam int unsigned DoneBit = done_bit(WIDTH);
  localparam int unsigned FilLsb  = fil_lsb(WIDTH);

  logic                             ts;
  logic                             accept;
  logic [NUM_BANKS-1:0]             wr_en;
  logic [DATA_W-1:0]                wr_data;
  logic [SIZE_W-1:0]                wr_size;
  logic                             wr_done;
  logic [NUM_BANKS-1:0][DATA_W-1:0] rd_word;
  logic [NUM_BANKS-1:0]             bank_full;
  logic [NUM_BANKS-1:0][SIZE_W-1:0] bank_size;
  logic [NUM_BANKS-1:0]             bank_err;

  logic              err_q;
  logic [FIL_W-1:0]  fil_size_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign ts      = bus.in_data[TS_BIT];
  assign wr_data = bus.in_data[DATA_LSB +: DATA_W];
  assign wr_size = bus.in_data[SIZE_LSB +: SIZE_W];
  assign wr_done = bus.in_data[DoneBit];

  // Accept steers the word to the bank named by the timestep bit.
  always_comb begin
    accept = bus.in_valid && !bank_full[ts];
    wr_en  = '0;
    if (accept) begin
      wr_en[ts] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ifmap_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[b]),
      .wr_data   (wr_data),
      .wr_size   (wr_size),
      .wr_done   (wr_done),
      .rel       (bus.release_req[b]),
      .rd_addr   (bus.rd_addr),
      .rd_word   (rd_word[b]),
      .full      (bank_full[b]),
      .size      (bank_size[b]),
      .err_pulse (bank_err[b])
    );
  end

  // Sticky error, filter size and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      fil_size_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      err_q      <= err_q | (|bank_err);
      rd_valid_q <= bus.rd_en;
      if (accept) begin
        fil_size_q <= bus.in_data[FilLsb +: FIL_W];
      end
      if (bus.rd_en) begin
        rd_data_q <= rd_word[bus.rd_bank];
      end
    end
  end

  assign bus.in_ready  = !bank_full[ts];
  assign bus.bank_full = bank_full;
  assign bus.bank_size = bank_size;
  assign bus.fil_size  = fil_size_q;
  assign bus.err       = err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ifmap_mem.sv
// Self-checking bench for ifmap_mem; read results go through a scoreboard queue.
module tb_ifmap_mem;
  import ifmap_mem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ifmap_mem_if bus ();

  ifmap_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [35:0] sb_q [$];
  logic [35:0] w4 [4];
  logic [35:0] big [111];
  logic [35:0] b1w [3];

  function automatic logic [45:0] mk(input logic done, input logic [1:0] fil,
                                     input logic [35:0] data, input logic [5:0] size,
                                     input logic ts);
    return {done, fil, data, size, ts};
  endfunction

  function automatic logic [35:0] rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[35:0];
  endfunction

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.rd_en       = 1'b0;
    bus.rd_bank     = 1'b0;
    bus.rd_addr     = '0;
    bus.release_req = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One accepted write; caller guarantees the bank is not full.
  task automatic wr(input logic ts, input logic [5:0] size, input logic [1:0] fil,
                    input logic done, input logic [35:0] data);
    bus.in_data  = mk(done, fil, data, size, ts);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic rd_issue(input logic b, input logic [6:0] a, input logic [35:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_bank = b;
    bus.rd_addr = a;
    sb_q.push_back(exp);
  endtask

  task automatic rd_collect(input string name);
    logic [35:0] e;
    @(posedge clk);
    #1 bus.rd_en = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b1 || sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s rd_valid got=%b want=1 (queued=%0d)", name, bus.rd_valid, sb_q.size());
      if (sb_q.size() != 0) e = sb_q.pop_front();
    end else begin
      e = sb_q.pop_front();
      if (bus.rd_data !== e) begin
        miscompares++;
        $display("FAIL %s rd_data got=%h want=%h", name, bus.rd_data, e);
      end
    end
  endtask

  task automatic rd(input logic b, input logic [6:0] a, input logic [35:0] exp,
                    input string name);
    rd_issue(b, a, exp);
    rd_collect(name);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.bank_full !== 2'b00) begin
      miscompares++; $display("FAIL rst_full got=%b want=00", bus.bank_full);
    end
    vectors++;
    if (bus.bank_size !== 12'h000 || bus.fil_size !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_size got=%h/%b want=000/00", bus.bank_size, bus.fil_size);
    end
    vectors++;
    if (bus.err !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 36'h0) begin
      miscompares++;
      $display("FAIL rst_rd got err=%b v=%b d=%h want 0", bus.err, bus.rd_valid, bus.rd_data);
    end
    bus.in_data = mk(1'b0, 2'b00, 36'h0, 6'd0, 1'b1);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_ready_b1 got=%b want=1", bus.in_ready);
    end
    bus.in_data = '0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_ready_b0 got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_size12();
    for (int i = 0; i < 4; i++) begin
      w4[i] = rnd36();
      wr(1'b0, 6'd12, 2'd2, 1'b0, w4[i]);
      if (i == 2) begin
        vectors++;
        if (bus.bank_full !== 2'b00) begin
          miscompares++; $display("FAIL s12_full3 got=%b want=00", bus.bank_full);
        end
      end
    end
    vectors++;
    if (bus.bank_full !== 2'b01) begin
      miscompares++; $display("FAIL s12_full4 got=%b want=01", bus.bank_full);
    end
    vectors++;
    if (bus.bank_size[0] !== 6'd12 || bus.err !== 1'b0 || bus.fil_size !== 2'd2) begin
      miscompares++;
      $display("FAIL s12_state got size=%0d err=%b fil=%0d want 12/0/2",
               bus.bank_size[0], bus.err, bus.fil_size);
    end
    for (int i = 0; i < 4; i++) rd(1'b0, 7'(i), w4[i], "s12_read");
    @(posedge clk);
    #1;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL s12_rdv_drop got=%b want=0", bus.rd_valid);
    end
  endtask

  task automatic test_release_ts1();
    logic [35:0] d1, d2;
    d1 = rnd36();
    d2 = rnd36();
    wr(1'b1, 6'd6, 2'd1, 1'b1, d1);
    vectors++;
    if (bus.bank_full !== 2'b11 || bus.bank_size[1] !== 6'd6 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL s6_done got full=%b size=%0d err=%b want 11/6/0",
               bus.bank_full, bus.bank_size[1], bus.err);
    end
    bus.in_data  = mk(1'b0, 2'd1, d2, 6'd6, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL s6_ready_full got=%b want=0", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.release_req = 2'b10;
    vectors++;
    if (bus.bank_full !== 2'b11) begin
      miscompares++; $display("FAIL s6_hold got=%b want=11", bus.bank_full);
    end
    @(posedge clk);
    #1 bus.release_req = 2'b00;
    vectors++;
    if (bus.bank_full !== 2'b01 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL s6_release got full=%b rdy=%b want 01/1", bus.bank_full, bus.in_ready);
    end
    // Bank-1 write lands while bank 0 is read in the same cycle.
    rd_issue(1'b0, 7'd2, w4[2]);
    rd_collect("s6_conc_read");
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.bank_full !== 2'b11) begin
      miscompares++; $display("FAIL s6_refill got=%b want=11", bus.bank_full);
    end
    rd(1'b1, 7'd0, d2, "s6_addr0");
    bus.release_req = 2'b10;
    @(posedge clk);
    #1 bus.release_req = 2'b10;
    @(posedge clk);
    #1 bus.release_req = 2'b00;
    vectors++;
    if (bus.bank_full !== 2'b01) begin
      miscompares++; $display("FAIL s6_rel_empty got=%b want=01", bus.bank_full);
    end
  endtask

  task automatic test_hold_off();
    logic [35:0] nw, nw2;
    nw  = rnd36();
    nw2 = rnd36();
    bus.in_data     = mk(1'b0, 2'd0, nw, 6'd12, 1'b0);
    bus.in_valid    = 1'b1;
    bus.release_req = 2'b01;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL hold_ready got=%b want=0", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.release_req = 2'b00;
    vectors++;
    if (bus.bank_full[0] !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_after got full0=%b rdy=%b want 0/1", bus.bank_full[0], bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rd(1'b0, 7'd0, nw, "hold_addr0");
    rd(1'b0, 7'd3, w4[3], "hold_retained");
    // Write addr 1 and read addr 1 together: old data comes back.
    bus.in_data  = mk(1'b0, 2'd0, nw2, 6'd12, 1'b0);
    bus.in_valid = 1'b1;
    rd_issue(1'b0, 7'd1, w4[1]);
    rd_collect("rw_old");
    bus.in_valid = 1'b0;
    rd(1'b0, 7'd1, nw2, "rw_new");
  endtask

  task automatic test_size63();
    int k;
    do_reset();
    k = 0;
    for (int i = 0; i < 111; i++) begin
      big[i] = rnd36();
      wr(1'b0, 6'd63, 2'd0, 1'b0, big[i]);
      if (i == 109) begin
        vectors++;
        if (bus.bank_full !== 2'b00) begin
          miscompares++; $display("FAIL s63_full110 got=%b want=00", bus.bank_full);
        end
      end
      if (i == 30 || i == 60 || i == 90) begin
        b1w[k] = rnd36();
        wr(1'b1, 6'd63, 2'd0, 1'b0, b1w[k]);
        k++;
      end
    end
    vectors++;
    if (bus.bank_full !== 2'b01) begin
      miscompares++; $display("FAIL s63_full111 got=%b want=01", bus.bank_full);
    end
    vectors++;
    if (bus.bank_size[0] !== 6'd63 || bus.bank_size[1] !== 6'd0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL s63_state got s0=%0d s1=%0d err=%b want 63/0/0",
               bus.bank_size[0], bus.bank_size[1], bus.err);
    end
    for (int j = 0; j < 3; j++) rd(1'b1, 7'(j), b1w[j], "s63_b1");
    rd(1'b0, 7'd0, big[0], "s63_first");
    rd(1'b0, 7'd110, big[110], "s63_last");
    rd(1'b0, 7'd111, 36'h0, "s63_oob111");
    rd(1'b0, 7'd127, 36'h0, "s63_oob127");
  endtask

  task automatic test_errors();
    do_reset();
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL err_clean got=%b want=0", bus.err);
    end
    wr(1'b0, 6'd12, 2'd0, 1'b1, rnd36());
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++; $display("FAIL err_early_done got=%b want=1", bus.err);
    end
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    vectors++;
    if (bus.err !== 1'b1 || bus.bank_full !== 2'b01) begin
      miscompares++;
      $display("FAIL err_sticky got err=%b full=%b want 1/01", bus.err, bus.bank_full);
    end
    do_reset();
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    wr(1'b0, 6'd8, 2'd0, 1'b0, rnd36());
    vectors++;
    if (bus.err !== 1'b1 || bus.bank_full !== 2'b00) begin
      miscompares++;
      $display("FAIL err_size got err=%b full=%b want 1/00", bus.err, bus.bank_full);
    end
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    wr(1'b0, 6'd12, 2'd0, 1'b0, rnd36());
    vectors++;
    if (bus.bank_full !== 2'b01 || bus.bank_size[0] !== 6'd12) begin
      miscompares++;
      $display("FAIL err_size_first got full=%b size=%0d want 01/12",
               bus.bank_full, bus.bank_size[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] a, b;
    a = rnd36();
    b = rnd36();
    do_reset();
    wr(1'b0, 6'd12, 2'd3, 1'b0, a);
    wr(1'b0, 6'd12, 2'd3, 1'b1, b);
    rd_issue(1'b0, 7'd1, b);
    rd_collect("mid_pre_read");
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.bank_full !== 2'b00 || bus.fil_size !== 2'd0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_state got full=%b fil=%0d err=%b want 00/0/0",
               bus.bank_full, bus.fil_size, bus.err);
    end
    vectors++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 36'h0 || bus.bank_size !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_rst_rd got v=%b d=%h size=%h want 0", bus.rd_valid, bus.rd_data,
               bus.bank_size);
    end
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_ready got=%b want=1", bus.in_ready);
    end
    wr(1'b0, 6'd12, 2'd1, 1'b0, rnd36());
    wr(1'b0, 6'd12, 2'd1, 1'b0, rnd36());
    vectors++;
    if (bus.bank_full !== 2'b00) begin
      miscompares++; $display("FAIL mid_full2 got=%b want=00", bus.bank_full);
    end
    wr(1'b0, 6'd12, 2'd1, 1'b0, rnd36());
    wr(1'b0, 6'd12, 2'd1, 1'b0, rnd36());
    vectors++;
    if (bus.bank_full !== 2'b01 || bus.bank_size[0] !== 6'd12) begin
      miscompares++;
      $display("FAIL mid_full4 got full=%b size=%0d want 01/12", bus.bank_full,
               bus.bank_size[0]);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_size12();
    test_release_ts1();
    test_hold_off();
    test_size63();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d vectors", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifmap_mem.md
IFMAP_MEM -- requirements
Module: ifmap_mem

Interface
REQ-001 Parameter WIDTH, default 45, decoder input-packet width; the write word is WIDTH+1 bits.
REQ-002 Parameter DATA_W, default 36, ifmap bits per stored word.
REQ-003 Parameter DEPTH, default 111, words per bank, equal to ceil(63*63/36).
REQ-004 Port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_valid, input, 1, write word offered by the instruction decoder.
REQ-007 Port in_ready, output, 1, the block accepts the word this cycle.
REQ-008 Port in_data, input, WIDTH+1, fields by bit:
- [WIDTH] done
- [WIDTH-1:WIDTH-2] filter size
- [WIDTH-3:7] ifmap data, 36 bits, LSB is the first pixel
- [6:1] ifmap size
- [0] timestep
REQ-009 Port rd_en, input, 1, read strobe.
REQ-010 Port rd_bank, input, 1, bank (timestep) to read.
REQ-011 Port rd_addr, input, 7, word address within the bank.
REQ-012 Port rd_data, output, DATA_W, registered read result.
REQ-013 Port rd_valid, output, 1, rd_data is valid.
REQ-014 Port release, input, 2, one-cycle pulse per bank that frees that bank.
REQ-015 Port bank_full, output, 2, bank holds a complete ifmap.
REQ-016 Port bank_size, output, 2x6, latched ifmap size per bank.
REQ-017 Port fil_size, output, 2, latched filter size from the last accepted word.
REQ-018 Port err, output, 1, sticky protocol error.

Function
REQ-019 The block SHALL accept a word on a cycle with in_valid=1 and in_ready=1; in_ready SHALL equal !bank_full[in_data[0]], which is combinational.
REQ-020 Accepted words SHALL go to bank in_data[0] at that bank's wr_ptr; wr_ptr SHALL then increment by 1.
REQ-021 Each bank SHALL keep a 12-bit bit_cnt, incremented by 36 per accepted word.
REQ-022 Bank completion SHALL be detected when (bit_cnt+36) >= size*size, using the size field of the current word. On the accepting cycle the block SHALL:
- set bank_full
- latch bank_size
- clear wr_ptr and bit_cnt
REQ-023 Size 0 SHALL complete on the first word.
REQ-024 done=1 on a word that does not complete its bank SHALL set err; that word SHALL still be stored.
REQ-025 done=0 on a completing word SHALL be legal, because timestep-0 words never carry done.
REQ-026 A size field that differs from the first word of the same bank SHALL set err; the first word's size SHALL be used.
REQ-027 An accept with wr_ptr==DEPTH SHALL drop the word and set err, with no pointer wrap.
REQ-028 fil_size SHALL update on every accepted word.
REQ-029 Reads SHALL have 1-cycle latency: rd_data=mem[rd_bank][rd_addr] and rd_valid=1 in the cycle after rd_en.
- rd_addr >= DEPTH SHALL return 0.
- Reads SHALL be permitted regardless of bank_full.
REQ-030 release[b] SHALL clear bank_full[b] next cycle; memory contents SHALL be retained.
REQ-031 release on a non-full bank SHALL have no effect.
REQ-032 When release[b] and an offered word for bank b occur in the same cycle, the word SHALL NOT be accepted, since in_ready is low; it SHALL be accepted on a following cycle.
REQ-033 Writes to one bank and reads or release of the other bank SHALL proceed concurrently in the same cycle.
REQ-034 A read and a write to the same bank and address in the same cycle SHALL return the old data.

Reset
REQ-035 Asserting rst_n=0 SHALL asynchronously reset the following to 0, including mid-operation:
- in_ready source state
- wr_ptr and bit_cnt for both banks
- bank_full, bank_size, fil_size
- rd_data, rd_valid, err
REQ-036 Memory array contents SHALL NOT be reset.
REQ-037 After deassertion, in_ready SHALL be 1 for both banks.

Structure
REQ-038 A shared package SHALL hold:
- field-position constants for the WIDTH+1 write word
- DATA_W
- DEPTH
- ifmap and filter size widths
REQ-039 One sub-module ifmap_bank SHALL hold a single bank's array, wr_ptr, bit_cnt, full flag and completion compare; it SHALL be instantiated twice.

Verification
REQ-040 Size 12, timestep 0, four words: bank_full[0]=1 after the 4th accept, bank_size[0]=12, err=0; reads of addr 0..3 return the words.
REQ-041 Size 6, timestep 1, one word with done=1: completes immediately. A second word while full sees in_ready=0; after release[1] it is accepted at addr 0.
REQ-042 Size 63, 111 words to bank 0 interleaved with 3 words to bank 1: bank 0 full after word 111, err=0; bank 1 unaffected.
REQ-043 Error cases: done=1 on word 2 of a size-12 map sets err=1. A size change mid-bank sets err. err stays set until reset.
REQ-044 rst_n pulsed low after 2 of 4 words: all outputs return to 0. A new size-12 sequence then completes after 4 words.
REQ-045 release[0] coincident with a bank-0 write: the write is held off one cycle. A same-address read/write returns the old data.
